// File: rtl/deconv_pkg.sv
// Shared definitions for the deconvolution output path.
//  - n_pix_out(): length of a transposed-conv output row (overlap-add)
//  - n_beat() / last_lanes(): beat count and occupied lanes on the final beat
//  - NBEAT_DEF / LAST_KEEP_DEF: values for the default geometry (8,5,2 / 4 px per beat)
//  - stream_state_e: row streamer FSM states
//  - pix_lsb(): LSB position of pixel idx in a packed row of acc_w-bit pixels
package deconv_pkg;

   function automatic int n_pix_out(input int feat, input int wt, input int stride);
      return feat * wt - (wt - stride) * (feat - 1);
   endfunction

   function automatic int n_beat(input int npix, input int beat_pix);
      return (npix + beat_pix - 1) / beat_pix;
   endfunction

   function automatic int last_lanes(input int npix, input int beat_pix);
      return npix - (n_beat(npix, beat_pix) - 1) * beat_pix;
   endfunction

   function automatic int pix_lsb(input int idx, input int acc_w);
      return idx * acc_w;
   endfunction

   localparam int N_PIX_OUT_DEF = n_pix_out(8, 5, 2);
   localparam int NBEAT_DEF     = n_beat(N_PIX_OUT_DEF, 4);
   localparam int LAST_KEEP_DEF = (1 << last_lanes(N_PIX_OUT_DEF, 4)) - 1;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } stream_state_e;

endpackage

// File: rtl/row_ring_buf.sv
// Row FIFO for the row streamer: DEPTH entries of W bits, ring pointers
// wrapping modulo DEPTH.
// Ports:
//  clk, rst_n   clock, async active-low reset (clears pointers and count)
//  push         write wr_data at the tail (caller guarantees room or a same-edge pop)
//  pop          retire the head entry (caller guarantees count != 0)
//  wr_data      row to store
//  head_data    oldest stored row
//  next_data    row behind the head, for back-to-back streaming across a pop
//  count        number of stored rows
//  full         count == DEPTH
module row_ring_buf #(
   parameter int DEPTH = 2,
   parameter int W     = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push,
   input  logic                         pop,
   input  logic [W-1:0]                 wr_data,
   output logic [W-1:0]                 head_data,
   output logic [W-1:0]                 next_data,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         full
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Storage is not reset; count/pointers define what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= ptr_inc(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= ptr_inc(rd_ptr);
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign head_data = mem[rd_ptr];
   assign next_data = mem[ptr_inc(rd_ptr)];
   assign full      = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/accum_row_streamer.sv
// Row streamer behind the overlap-add accumulator. Captures finished rows
// (single-cycle pulse, no backpressure) into a small ring buffer and sends
// each row as NBEAT beats of BEAT_PIX pixels on a valid/ready master port
// feeding the writeback DMA.
// Optional build macro: ACCUM_ROW_SAT_EN -- clamp each pixel to
// [0, 2^PIX_WIDTH-1] (unsigned) at beat load; otherwise raw pass-through.
// Ports:
//  clk, rst_n    clock, async active-low reset
//  row_valid_i   one-cycle pulse, row_data_i holds a finished row
//  row_data_i    N_PIX_OUT pixels of 2*PIX_WIDTH bits, pixel 0 in the LSBs
//  m_valid       beat valid (registered)
//  m_ready       beat accepted when m_valid && m_ready
//  m_data        beat; lane j = pixel beat_idx*BEAT_PIX+j, unused lanes 0
//  m_keep        per-lane valid
//  m_last        final beat of a row
//  buf_full_o    row buffer holds ROW_DEPTH rows
//  ovf_o         sticky: a row arrived with no room and was dropped
//  clr_ovf_i     synchronous clear of ovf_o (a coincident drop wins)
//
// state | meaning
// IDLE  | no beat presented; waiting for a buffered row
// SEND  | output regs hold a beat of the head row, m_valid=1
module accum_row_streamer
   import deconv_pkg::*;
#(
   parameter int PIX_WIDTH       = 8,
   parameter int SIZE_OF_FEATURE = 8,
   parameter int SIZE_OF_WEIGHT  = 5,
   parameter int STRIDE          = 2,
   parameter int N_PIX_OUT       = n_pix_out(SIZE_OF_FEATURE, SIZE_OF_WEIGHT, STRIDE),
   parameter int BEAT_PIX        = 4,
   parameter int ROW_DEPTH       = 2
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              row_valid_i,
   input  logic [2*PIX_WIDTH*N_PIX_OUT-1:0]  row_data_i,
   output logic                              m_valid,
   input  logic                              m_ready,
   output logic [2*PIX_WIDTH*BEAT_PIX-1:0]   m_data,
   output logic [BEAT_PIX-1:0]               m_keep,
   output logic                              m_last,
   output logic                              buf_full_o,
   output logic                              ovf_o,
   input  logic                              clr_ovf_i
);

   localparam int ACC_W      = 2 * PIX_WIDTH;
   localparam int ROW_W      = ACC_W * N_PIX_OUT;
   localparam int BEAT_W     = ACC_W * BEAT_PIX;
   localparam int NBEAT      = n_beat(N_PIX_OUT, BEAT_PIX);
   localparam int PAD_W      = NBEAT * BEAT_W;
   localparam int BI_W       = (NBEAT > 1) ? $clog2(NBEAT) : 1;
   localparam int CNT_W      = $clog2(ROW_DEPTH + 1);
   localparam logic [BI_W-1:0]     LAST_IDX  = BI_W'(NBEAT - 1);
   localparam logic [BEAT_PIX-1:0] LAST_KEEP =
      BEAT_PIX'((1 << last_lanes(N_PIX_OUT, BEAT_PIX)) - 1);

   stream_state_e     state, state_nxt;
   logic [BI_W-1:0]   beat_idx, beat_idx_nxt;
   logic              m_valid_nxt;
   logic [BEAT_W-1:0] m_data_nxt;
   logic [BEAT_PIX-1:0] m_keep_nxt;
   logic              m_last_nxt;

   logic              push, pop, full;
   logic [ROW_W-1:0]  head_data, next_data;
   logic [CNT_W-1:0]  count;

   logic              load;
   logic [ROW_W-1:0]  load_row;
   logic [BI_W-1:0]   load_idx;

   // A full buffer still accepts a row when the head retires at the same edge.
   assign push = row_valid_i && (!full || pop);

   row_ring_buf #(
      .DEPTH (ROW_DEPTH),
      .W     (ROW_W)
   ) u_ring (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .pop       (pop),
      .wr_data   (row_data_i),
      .head_data (head_data),
      .next_data (next_data),
      .count     (count),
      .full      (full)
   );

   // Zero-padding the row to NBEAT*BEAT_PIX pixels drives unused last-beat lanes to 0.
   function automatic logic [BEAT_W-1:0] build_beat(input logic [ROW_W-1:0] row,
                                                    input logic [BI_W-1:0]  idx);
      logic [PAD_W-1:0]  pad;
      logic [BEAT_W-1:0] beat;
      pad  = PAD_W'(row);
      beat = pad[pix_lsb(int'(idx) * BEAT_PIX, ACC_W) +: BEAT_W];
`ifdef ACCUM_ROW_SAT_EN
      for (int j = 0; j < BEAT_PIX; j++) begin
         if (|beat[pix_lsb(j, ACC_W) + PIX_WIDTH +: PIX_WIDTH]) begin
            beat[pix_lsb(j, ACC_W) +: ACC_W] = {{PIX_WIDTH{1'b0}}, {PIX_WIDTH{1'b1}}};
         end
      end
`endif
      return beat;
   endfunction

   always_comb begin
      state_nxt    = state;
      beat_idx_nxt = beat_idx;
      m_valid_nxt  = m_valid;
      m_data_nxt   = m_data;
      m_keep_nxt   = m_keep;
      m_last_nxt   = m_last;
      pop          = 1'b0;
      load         = 1'b0;
      load_row     = head_data;
      load_idx     = '0;

      case (state)
         IDLE: begin
            if (count != '0) begin
               load         = 1'b1;
               beat_idx_nxt = '0;
               m_valid_nxt  = 1'b1;
               state_nxt    = SEND;
            end
         end
         SEND: begin
            if (m_ready) begin
               if (beat_idx != LAST_IDX) begin
                  load         = 1'b1;
                  load_idx     = beat_idx + 1'b1;
                  beat_idx_nxt = beat_idx + 1'b1;
               end else begin
                  pop          = 1'b1;
                  beat_idx_nxt = '0;
                  // Only rows already buffered continue back-to-back; a row
                  // arriving on this edge is picked up from IDLE.
                  if (count > CNT_W'(1)) begin
                     load     = 1'b1;
                     load_row = next_data;
                  end else begin
                     m_valid_nxt = 1'b0;
                     m_last_nxt  = 1'b0;
                     state_nxt   = IDLE;
                  end
               end
            end
         end
         default: state_nxt = IDLE;
      endcase

      if (load) begin
         m_data_nxt = build_beat(load_row, load_idx);
         m_keep_nxt = (load_idx == LAST_IDX) ? LAST_KEEP : '1;
         m_last_nxt = (load_idx == LAST_IDX);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         beat_idx <= '0;
         m_valid  <= 1'b0;
         m_data   <= '0;
         m_keep   <= '0;
         m_last   <= 1'b0;
      end else begin
         state    <= state_nxt;
         beat_idx <= beat_idx_nxt;
         m_valid  <= m_valid_nxt;
         m_data   <= m_data_nxt;
         m_keep   <= m_keep_nxt;
         m_last   <= m_last_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_o <= 1'b0;
      end else if (row_valid_i && !push) begin
         ovf_o <= 1'b1;
      end else if (clr_ovf_i) begin
         ovf_o <= 1'b0;
      end
   end

   assign buf_full_o = full;

endmodule

// File: tb/tb_accum_row_streamer.sv
// Self-checking bench for accum_row_streamer (default geometry: 19 pixels
// of 16 bits, 4-pixel beats, 2-row buffer). Expected beats are queued when
// a row is driven and compared as the DUT hands beats off.
module tb_accum_row_streamer;

   localparam int ROW_W = 16 * 19;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              row_valid_i;
   logic [ROW_W-1:0]  row_data_i;
   logic              m_valid;
   logic              m_ready;
   logic [63:0]       m_data;
   logic [3:0]        m_keep;
   logic              m_last;
   logic              buf_full_o;
   logic              ovf_o;
   logic              clr_ovf_i;

   typedef struct {
      logic [63:0] data;
      logic [3:0]  keep;
      logic        last;
   } beat_t;

   beat_t sb[$];
   int    n_chk  = 0;
   int    n_pass = 0;

   always #5 clk = ~clk;

   accum_row_streamer dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .row_valid_i (row_valid_i),
      .row_data_i  (row_data_i),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .m_data      (m_data),
      .m_keep      (m_keep),
      .m_last      (m_last),
      .buf_full_o  (buf_full_o),
      .ovf_o       (ovf_o),
      .clr_ovf_i   (clr_ovf_i)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   function automatic logic [15:0] sat16(input logic [15:0] v);
`ifdef ACCUM_ROW_SAT_EN
      return (v > 16'h00FF) ? 16'h00FF : v;
`else
      return v;
`endif
   endfunction

   function automatic logic [ROW_W-1:0] make_row(input int base);
      logic [ROW_W-1:0] r;
      r = '0;
      for (int i = 0; i < 19; i++) r[i*16 +: 16] = 16'(base + i);
      return r;
   endfunction

   task automatic expect_row(input logic [ROW_W-1:0] row);
      beat_t b;
      for (int k = 0; k < 5; k++) begin
         b.data = '0;
         for (int j = 0; j < 4; j++) begin
            if (k * 4 + j < 19) b.data[j*16 +: 16] = sat16(row[(k*4+j)*16 +: 16]);
         end
         b.keep = (k == 4) ? 4'b0111 : 4'b1111;
         b.last = (k == 4);
         sb.push_back(b);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic push_row(input logic [ROW_W-1:0] row, input bit accept);
      row_data_i  = row;
      row_valid_i = 1'b1;
      if (accept) expect_row(row);
      tick();
      row_valid_i = 1'b0;
   endtask

   task automatic drain(input int max);
      int cyc;
      cyc = 0;
      while (sb.size() != 0 && cyc < max) begin
         @(negedge clk);
         cyc++;
      end
      if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 64'd0);
      tick();
      @(negedge clk);
      chk("drain_idle_valid", {63'd0, m_valid}, 64'd0);
   endtask

   // Scoreboard and stall-stability monitor.
   logic        stalled = 1'b0;
   logic [63:0] pd;
   logic [3:0]  pk;
   logic        pl;

   always @(negedge clk) begin
      beat_t e;
      if (!rst_n) begin
         stalled = 1'b0;
      end else begin
         if (stalled) begin
            chk("stall_valid", {63'd0, m_valid}, 64'd1);
            chk("stall_data",  m_data, pd);
            chk("stall_keep",  {60'd0, m_keep}, {60'd0, pk});
            chk("stall_last",  {63'd0, m_last}, {63'd0, pl});
         end
         if (m_valid && m_ready) begin
            if (sb.size() == 0) begin
               chk("unexpected_beat", {63'd0, m_valid}, 64'd0);
            end else begin
               e = sb.pop_front();
               chk("beat_data", m_data, e.data);
               chk("beat_keep", {60'd0, m_keep}, {60'd0, e.keep});
               chk("beat_last", {63'd0, m_last}, {63'd0, e.last});
            end
         end
         stalled = m_valid && !m_ready;
         pd = m_data;
         pk = m_keep;
         pl = m_last;
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [ROW_W-1:0] r;
      logic [6:0]       vrun;
      int               hs, cyc, nv;

      rst_n       = 1'b0;
      row_valid_i = 1'b0;
      row_data_i  = '0;
      m_ready     = 1'b0;
      clr_ovf_i   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", {63'd0, m_valid}, 64'd0);
      chk("rst_data",  m_data, 64'd0);
      chk("rst_keep",  {60'd0, m_keep}, 64'd0);
      chk("rst_last",  {63'd0, m_last}, 64'd0);
      chk("rst_full",  {63'd0, buf_full_o}, 64'd0);
      chk("rst_ovf",   {63'd0, ovf_o}, 64'd0);
      rst_n = 1'b1;
      tick();

      // 1: single row, ready held high
      m_ready = 1'b1;
      push_row(make_row(1), 1'b1);
      @(negedge clk);
      chk("t1_latency", {63'd0, m_valid}, 64'd0);
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         vrun[i] = m_valid;
      end
      chk("t1_valid_run", {57'd0, vrun}, {57'd0, 7'b0011111});
      chk("t1_drained", 64'(sb.size()), 64'd0);

      // 2: ready toggles 1,0,1,0,...
      m_ready = 1'b0;
      push_row(make_row(1), 1'b1);
      tick();
      chk("t2_first_valid", {63'd0, m_valid}, 64'd1);
      hs = 0; cyc = 0;
      for (int i = 0; i < 30 && hs < 5; i++) begin
         m_ready = (i % 2 == 0);
         @(negedge clk);
         if (m_valid && m_ready) hs++;
         cyc = i + 1;
         tick();
      end
      chk("t2_cycles", 64'(cyc), 64'd9);
      m_ready = 1'b1;
      drain(20);

      // 3: overflow with a stalled sink, then release
      m_ready = 1'b0;
      push_row(make_row(100), 1'b1);
      push_row(make_row(200), 1'b1);
      push_row(make_row(300), 1'b0);
      @(negedge clk);
      chk("t3_full", {63'd0, buf_full_o}, 64'd1);
      chk("t3_ovf",  {63'd0, ovf_o}, 64'd1);
      tick();
      m_ready = 1'b1;
      hs = 0; cyc = 0;
      while (hs < 10 && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (m_valid && m_ready) hs++;
         if (hs < 10) tick();
      end
      chk("t3_cycles", 64'(cyc), 64'd10);
      drain(10);
      chk("t3_ovf_sticky", {63'd0, ovf_o}, 64'd1);
      chk("t3_not_full",   {63'd0, buf_full_o}, 64'd0);
      clr_ovf_i = 1'b1;
      tick();
      clr_ovf_i = 1'b0;
      @(negedge clk);
      chk("t3_ovf_clr", {63'd0, ovf_o}, 64'd0);

      // 4: push into a full buffer on the final-beat handshake
      m_ready = 1'b0;
      push_row(make_row(400), 1'b1);
      push_row(make_row(500), 1'b1);
      m_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (m_valid && m_last) break;
      end
      chk("t4_at_last", {63'd0, m_last}, 64'd1);
      r = make_row(600);
      row_data_i  = r;
      row_valid_i = 1'b1;
      expect_row(r);
      tick();
      row_valid_i = 1'b0;
      @(negedge clk);
      chk("t4_ovf",  {63'd0, ovf_o}, 64'd0);
      chk("t4_full", {63'd0, buf_full_o}, 64'd1);
      drain(40);
      chk("t4_ovf_end", {63'd0, ovf_o}, 64'd0);

      // 5: reset during beat 2
      m_ready = 1'b1;
      push_row(make_row(700), 1'b1);
      hs = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (m_valid && hs == 2) break;
         if (m_valid && m_ready) hs++;
      end
      chk("t5_reached_beat2", 64'(hs), 64'd2);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t5_rst_valid", {63'd0, m_valid}, 64'd0);
      chk("t5_rst_data",  m_data, 64'd0);
      chk("t5_rst_keep",  {60'd0, m_keep}, 64'd0);
      chk("t5_rst_last",  {63'd0, m_last}, 64'd0);
      sb.delete();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      nv = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (m_valid) nv++;
      end
      chk("t5_no_beats", 64'(nv), 64'd0);
      chk("t5_full", {63'd0, buf_full_o}, 64'd0);
      tick();
      push_row(make_row(800), 1'b1);
      drain(20);

      // 6: saturation (or pass-through) of large pixels
      r = make_row(16'h00F5);
      r[15:0]  = 16'h0123;
      r[31:16] = 16'h0080;
      push_row(r, 1'b1);
      @(negedge clk);
      @(negedge clk);
`ifdef ACCUM_ROW_SAT_EN
      chk("t6_pix0", {48'd0, m_data[15:0]}, 64'h00FF);
`else
      chk("t6_pix0", {48'd0, m_data[15:0]}, 64'h0123);
`endif
      chk("t6_pix1", {48'd0, m_data[31:16]}, 64'h0080);
      drain(20);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
